// File: rtl/frame_pack_writer.sv
// frame_pack_writer
//   Quantizes incoming 24-bit RGB pixels to 8-bit RGB332 form, packs four of
//   them into a 32-bit word, buffers the words in a small FIFO and writes them
//   out through a simple request/acknowledge memory port at consecutive word
//   addresses that wrap once per frame.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   pix_valid   rgb_in carries a pixel this cycle
//   rgb_in      pixel {R[23:16], G[15:8], B[7:0]}
//   sof         start-of-frame strobe: drops partial data, flushes, restarts at 0
//   mem_addr    word address of the pending write
//   mem_data    packed word of the pending write (pixel k in bits 8k+7:8k)
//   mem_we      write request, held until mem_ack
//   mem_ack     one-cycle acknowledge of the pending write
//   frame_done  one-cycle pulse after the last word of a frame is acknowledged
//   overflow    sticky: a packed word was dropped because the FIFO was full
module frame_pack_writer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [23:0]       rgb_in,
    input  logic              sof,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              frame_done,
    output logic              overflow
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                WORDS     = IMG_W * IMG_H / 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic              load;
    logic              pop;

    logic [1:0]        pack_cnt;
    logic [23:0]       pack_word;
    logic [7:0]        pix_q;
    logic              push;
    logic              push_ok;
    logic [31:0]       push_word;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_empty;

    // RGB332: top three bits of red and green, top two of blue.
    assign pix_q     = {rgb_in[23:21], rgb_in[15:13], rgb_in[7:6]};

    // The fourth pixel completes the word directly from the input; it never
    // sits in pack_word. A pixel arriving with sof always starts a new group.
    assign push      = pix_valid && !sof && (pack_cnt == 2'd3);
    assign push_word = {pix_q, pack_word};

    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok    = push && (!fifo_full || pop);

    // ------------------------------------------------------------------
    // Pixel packer
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_cnt  <= 2'd0;
            pack_word <= 24'd0;
        end else if (sof) begin
            if (pix_valid) begin
                pack_cnt        <= 2'd1;
                pack_word[7:0]  <= pix_q;
            end else begin
                pack_cnt        <= 2'd0;
            end
        end else if (pix_valid) begin
            case (pack_cnt)
                2'd0:    pack_word[7:0]   <= pix_q;
                2'd1:    pack_word[15:8]  <= pix_q;
                2'd2:    pack_word[23:16] <= pix_q;
                default: ;
            endcase
            pack_cnt <= pack_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else if (sof) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: ;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers and count define which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_word;
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        mem_we  = (state_q == REQ);
        case (state_q)
            IDLE: if (!fifo_empty) begin
                state_d = REQ;
                load    = 1'b1;
            end
            REQ:  if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (sof) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    // Acknowledges only count while a write is pending and no sof restarts
    // the frame.
    assign pop = mem_we && mem_ack && !sof;

    // ------------------------------------------------------------------
    // Memory-side datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            mem_data   <= 32'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sof) begin
                mem_addr <= '0;
            end else begin
                if (load) mem_data <= fifo_mem[rd_ptr];
                if (pop) begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_addr   <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        mem_addr   <= mem_addr + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/frame_pack_writer.md
FRAME_PACK_WRITER -- requirements
Module: frame_pack_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 640: active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480: active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17: word address width; IMG_W*IMG_H/4 SHALL fit in it.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: word FIFO depth, a power of two.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 pix_valid  in  1  rgb_in carries a pixel this cycle.
REQ-008 rgb_in  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-009 sof  in  1  start-of-frame strobe.
REQ-010 mem_addr  out  ADDR_W  word address of the pending write.
REQ-011 mem_data  out  32  packed word of the pending write.
REQ-012 mem_we  out  1  write request; held until acknowledged.
REQ-013 mem_ack  in  1  one-cycle acknowledge of the pending write.
REQ-014 frame_done  out  1  one-cycle pulse when the last word of a frame is acknowledged.
REQ-015 overflow  out  1  sticky flag: a word was dropped.

Function
REQ-016 Each valid pixel SHALL be quantized to 8 bits as {R[7:5],G[7:5],B[7:6]}.
REQ-017 Pixel k (0..3) of a group SHALL occupy mem_data[8k+7:8k]; a 2-bit pack counter SHALL count valid pixels.
REQ-018 On the 4th valid pixel of a group, the complete word SHALL be pushed into the FIFO at that clock edge, and the counter SHALL wrap to 0.
REQ-019 A push to a full FIFO SHALL be dropped and SHALL set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-020 Write FSM states: IDLE, REQ.
REQ-021 IDLE -> REQ when the FIFO is non-empty; on entry, mem_data SHALL be loaded with the FIFO head and mem_we SHALL be driven to 1.
REQ-022 In REQ, mem_addr, mem_data and mem_we SHALL remain stable until a cycle with mem_ack=1.
REQ-023 At an edge with mem_we=1 and mem_ack=1: pop the FIFO, increment mem_addr, drop mem_we, and return to IDLE (minimum one idle cycle between writes).
REQ-024 mem_ack while in IDLE SHALL be ignored.
REQ-025 Latency: mem_we SHALL first be high 2 cycles after the 4th pixel is presented, when the FIFO was empty and the FSM was in IDLE.
REQ-026 Address wrap: an acknowledge at address IMG_W*IMG_H/4-1 SHALL set mem_addr to 0 and pulse frame_done for exactly one cycle.
REQ-027 sof=1 SHALL, at that edge, perform all of the following:
  - clear the pack counter, discarding any partial group;
  - flush the FIFO;
  - set mem_addr to 0;
  - force the FSM to IDLE with mem_we=0, abandoning any unacknowledged write;
  - clear overflow.
REQ-028 A pixel with pix_valid=1 in the same cycle as sof SHALL become pixel 0 of the new frame.
REQ-029 mem_ack in the same cycle as sof SHALL be ignored, with no frame_done pulse.
REQ-030 pix_valid=0 cycles SHALL leave the pack state unchanged; gaps of any length are legal.

Reset
REQ-031 While rst=0, all of the following SHALL hold asynchronously:
  - mem_we=0, mem_addr=0, mem_data=0, frame_done=0, overflow=0;
  - pack counter 0, FIFO empty, FSM in IDLE.
REQ-032 Reset deassertion mid-frame SHALL start at address 0; no partial word SHALL be retained.

Verification
REQ-033 Pixels 0x200000, 0x00E000, 0x0000C0, 0xFFFFFF on consecutive cycles, mem_ack tied 1 -> mem_data=0xFF031C20 at mem_addr=0, mem_we high for 1 cycle starting 2 cycles after the 4th pixel, then mem_addr=1.
REQ-034 mem_ack held 0 while 17 words (68 pixels) stream in, FIFO_DEPTH=16 -> mem_we held high on word 0 with stable data; FIFO fills with 16 words; the 17th push drops; overflow=1; acknowledged data matches words 0..15 in order.
REQ-035 IMG_W=8, IMG_H=2, 16 pixels, then mem_ack asserted -> addresses 0..3, frame_done pulses once on the ack at address 3, mem_addr returns to 0.
REQ-036 6 pixels, then sof with a valid pixel, then 3 more pixels -> partial group discarded; first word comes from the sof pixel plus the 3 that follow, at address 0; overflow cleared.
REQ-037 rst pulled low while mem_we=1 -> mem_we=0 immediately without a clock; after release, 4 pixels produce a write at address 0.
REQ-038 FIFO full and a mem_ack pop in the same cycle as a 4th-pixel push -> push accepted, overflow stays 0, FIFO count unchanged.
